// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: captures the raw reset asynchronously and releases it through a synchroniser.
// After a minimum hold, the domain resets are released one at a time; a software request replays the sequence.
module rst_seq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DOM     = 3,
  parameter int STRETCH     = 3,
  parameter int GAP         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  output logic [NUM_DOM-1:0] rst_n_out,
  output logic               busy,
  output logic               done,
  output logic               sw_ack
);

  localparam int CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] STRETCH_M1 = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GAP_M1     = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    IDLE    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [NUM_DOM-1:0] rst_out_reg, rst_out_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               sw_ack_reg, sw_ack_next;

  logic               rel_en;
  logic               clr_out;
  logic [IDX_W-1:0]   rel_idx;
  logic [NUM_DOM-1:0] rel_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // The edge that first sees the synchroniser high already counts as the first hold cycle,
  // so SYNC shares the hold step with HOLD (cnt is still zero there).
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    sw_ack_next = 1'b0;
    rel_en      = 1'b0;
    rel_idx     = idx_reg;
    clr_out     = 1'b0;
    case (state_reg)
      SYNC, HOLD: begin
        if (state_reg == HOLD || sync_out) begin
          if (cnt_reg == STRETCH_M1) begin
            rel_en   = 1'b1;
            rel_idx  = '0;
            idx_next = '0;
            cnt_next = '0;
            if (NUM_DOM == 1) begin
              state_next = IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              state_next = RELEASE;
            end
          end else begin
            cnt_next   = cnt_reg + 1'b1;
            state_next = HOLD;
          end
        end
      end
      RELEASE: begin
        if (cnt_reg == GAP_M1) begin
          cnt_next = '0;
          idx_next = idx_reg + 1'b1;
          rel_en   = 1'b1;
          rel_idx  = idx_reg + 1'b1;
          if (idx_reg + 1'b1 == LAST_IDX) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      IDLE: begin
        if (sw_rst_req) begin
          state_next  = HOLD;
          cnt_next    = '0;
          idx_next    = '0;
          busy_next   = 1'b1;
          sw_ack_next = 1'b1;
          clr_out     = 1'b1;
        end
      end
      default: begin
        state_next = SYNC;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_rel
    assign rel_mask[gi] = rel_en && (rel_idx == IDX_W'(gi));
  end

  // Released bits are sticky; only a restart clears them.
  always_comb begin
    rst_out_next = clr_out ? '0 : (rst_out_reg | rel_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= SYNC;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      rst_out_reg <= '0;
      busy_reg    <= 1'b1;
      done_reg    <= 1'b0;
      sw_ack_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      rst_out_reg <= rst_out_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      sw_ack_reg  <= sw_ack_next;
    end
  end

  assign rst_n_out = rst_out_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign sw_ack    = sw_ack_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected per-cycle outputs are queued when stimulus is applied.
// The queue is drained by a monitor sampling 1 ns after each rising edge.
module tb_rst_seq_ctrl;

  localparam int SS = 2;
  localparam int ND = 3;
  localparam int ST = 3;
  localparam int GP = 4;
  localparam int LAST_POR = SS + ST + (ND - 1) * GP;
  localparam int LAST_SW  = ST + (ND - 1) * GP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_rst_req = 1'b0;
  logic [ND-1:0] rst_n_out;
  logic          busy;
  logic          done;
  logic          sw_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit prop_en = 1'b0;

  typedef struct {
    int            cyc;
    logic [ND-1:0] rst;
    logic          busy;
    logic          done;
    logic          ack;
  } exp_t;

  exp_t sb_q[$];

  rst_seq_ctrl #(
    .SYNC_STAGES(SS),
    .NUM_DOM    (ND),
    .STRETCH    (ST),
    .GAP        (GP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_rst_req(sw_rst_req),
    .rst_n_out (rst_n_out),
    .busy      (busy),
    .done      (done),
    .sw_ack    (sw_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [ND-1:0] mask_of(input int rel);
    logic [ND-1:0] m;
    m = '0;
    for (int i = 0; i < rel; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic push_entry(input int c, input int rel, input bit b, input bit d, input bit a);
    exp_t e;
    e.cyc  = c;
    e.rst  = mask_of(rel);
    e.busy = b;
    e.done = d;
    e.ack  = a;
    sb_q.push_back(e);
  endtask

  // base is the edge count before E1; domain i releases at E(SS+ST+i*GP).
  task automatic push_por(input int base);
    for (int k = 1; k <= LAST_POR + 2; k++) begin
      int rel;
      rel = 0;
      for (int i = 0; i < ND; i++) if (SS + ST + i * GP <= k) rel++;
      push_entry(base + k, rel, k < LAST_POR, k == LAST_POR, 1'b0);
    end
  endtask

  // s is the accepting edge; domain i releases at s+ST+i*GP.
  task automatic push_sw(input int s, input int kend);
    for (int k = 0; k <= kend; k++) begin
      int rel;
      rel = 0;
      for (int i = 0; i < ND; i++) if (ST + i * GP <= k) rel++;
      push_entry(s + k, rel, k < LAST_SW, k == LAST_SW, k == 0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_rst"}, 32'(rst_n_out), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_ack"}, 32'(sw_ack), 32'd0);
  endtask

  initial begin
    exp_t       e;
    logic [1:0] st;
    logic [1:0] prev_st;
    logic [ND-1:0] nxt;
    prev_st = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      st = dut.state_reg;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          check_val("sb_missed", 32'(cyc), 32'(e.cyc));
        end else begin
          check_val("rst_n_out", 32'(rst_n_out), 32'(e.rst));
          check_val("busy", 32'(busy), 32'(e.busy));
          check_val("done", 32'(done), 32'(e.done));
          check_val("sw_ack", 32'(sw_ack), 32'(e.ack));
          $display("txn cyc=%0d rst_n_out=%b busy=%b done=%b sw_ack=%b", cyc, rst_n_out, busy, done, sw_ack);
        end
      end
      if (prop_en) begin
        nxt = rst_n_out + 1'b1;
        check_val("monotonic", 32'((rst_n_out & nxt) == '0), 32'd1);
        check_val("done_all_ones", 32'(!done || (&rst_n_out)), 32'd1);
        check_val("ack_in_idle", 32'(!sw_ack || prev_st == 2'd3), 32'd1);
        check_val("busy_state", 32'(busy), 32'(st != 2'd3));
      end
      prev_st = st;
    end
  end

  initial begin
    int s;
    // Power-on: held low three cycles
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_state("por_hold");
    end
    prop_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    push_por(cyc);
    wait_drain();

    // Sub-cycle glitch while idle
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("glitch");
    #3;
    rst_n = 1'b1;
    push_por(cyc);
    wait_drain();

    // Single-cycle software request
    @(negedge clk);
    sw_rst_req = 1'b1;
    push_sw(cyc + 1, LAST_SW + 2);
    @(negedge clk);
    sw_rst_req = 1'b0;
    wait_drain();

    // Request held for 20 cycles: one ack per sequence, re-accepted right after done
    @(negedge clk);
    sw_rst_req = 1'b1;
    s = cyc + 1;
    push_sw(s, LAST_SW);
    push_sw(s + LAST_SW + 1, LAST_SW + 3);
    repeat (20) @(negedge clk);
    sw_rst_req = 1'b0;
    wait_drain();

    // Raw reset pulsed when two domains are out
    @(negedge clk);
    sw_rst_req = 1'b1;
    push_sw(cyc + 1, ST + GP);
    @(negedge clk);
    sw_rst_req = 1'b0;
    wait_drain();
    check_val("mid_pre_rst", 32'(rst_n_out), 32'b011);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    push_por(cyc);
    wait_drain();

    // rst_n low beats a simultaneous request; requests outside idle are ignored
    @(negedge clk);
    sw_rst_req = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("simul");
    @(negedge clk);
    sw_rst_req = 1'b0;
    rst_n = 1'b1;
    push_por(cyc);
    repeat (3) @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    repeat (4) @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    wait_drain();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
